// File: rtl/regbank_dump_reader.sv
// Debug-side register bank dump reader: walks an index range through one bank
// read port and streams each captured word out over valid/ready.
module regbank_dump_reader #(
  parameter int unsigned REGISTER_LENGTH = 32,
  parameter int unsigned NUM_REGS        = 17,
  parameter int unsigned INDEX_WIDTH     = 5,
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic                       fast_clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INDEX_WIDTH-1:0]     first_reg,
  input  logic [INDEX_WIDTH-1:0]     last_reg,
  input  logic                       abort,
  output logic [INDEX_WIDTH-1:0]     bank_addr,
  input  logic [REGISTER_LENGTH-1:0] bank_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REGISTER_LENGTH-1:0] out_data,
  output logic [INDEX_WIDTH-1:0]     out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0]     r_idx, w_idx_nxt;
  logic [INDEX_WIDTH-1:0]     r_end, w_end_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [INDEX_WIDTH-1:0]     r_bank_addr, w_bank_addr_nxt;
  logic                       r_out_valid, w_out_valid_nxt;
  logic [REGISTER_LENGTH-1:0] r_out_data, w_out_data_nxt;
  logic [INDEX_WIDTH-1:0]     r_out_index, w_out_index_nxt;
  logic                       r_out_last, w_out_last_nxt;
  logic                       r_busy, w_busy_nxt;
  logic                       r_done, w_done_nxt;
  logic                       r_error, w_error_nxt;
  logic                       w_range_ok;
  logic                       w_accept;

  assign w_range_ok = (first_reg <= last_reg) && (32'(last_reg) < NUM_REGS);
  assign w_accept   = r_out_valid && out_ready;

  // State and output registers
  always_ff @(posedge fast_clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_end       <= '0;
      r_cnt       <= '0;
      r_bank_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_end       <= w_end_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bank_addr <= w_bank_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_index <= w_out_index_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  // Next-state and next-output logic; bank_addr is loaded on entry to ISSUE
  // so the address is already on the port for the whole ISSUE cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_end_nxt       = r_end;
    w_cnt_nxt       = r_cnt;
    w_bank_addr_nxt = r_bank_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_index_nxt = r_out_index;
    w_out_last_nxt  = r_out_last;
    w_done_nxt      = 1'b0;
    w_error_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_range_ok) begin
            w_idx_nxt       = first_reg;
            w_end_nxt       = last_reg;
            w_bank_addr_nxt = first_reg;
            w_state_nxt     = S_ISSUE;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = CNT_W'(READ_LATENCY);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_out_data_nxt  = bank_data;
          w_out_index_nxt = r_idx;
          w_out_last_nxt  = (r_idx == r_end);
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          w_out_valid_nxt = 1'b0;
          if (r_out_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt       = r_idx + INDEX_WIDTH'(1);
            w_bank_addr_nxt = r_idx + INDEX_WIDTH'(1);
            w_state_nxt     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle acceptance
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_out_valid_nxt = 1'b0;
      w_done_nxt      = 1'b0;
      w_bank_addr_nxt = r_bank_addr;
    end
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  assign bank_addr = r_bank_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Self-checking bench for regbank_dump_reader: directed table, corner sequences,
// and randomized dumps scored against a transaction-level model of the bank.
module tb_regbank_dump_reader;

  logic        fast_clock;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        abort;
  logic [4:0]  bank_addr;
  logic [31:0] bank_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:16];

  regbank_dump_reader dut (
    .fast_clock(fast_clock),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .bank_addr (bank_addr),
    .bank_data (bank_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  // Bank with one cycle of read latency
  always @(posedge fast_clock) begin
    if (bank_addr < 5'd17) bank_data <= mem[bank_addr];
    else                   bank_data <= 32'h0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        last;
  } word_t;

  typedef struct {
    int n;
    int done_cyc;
    int done_cnt;
    int err_cyc;
    int err_cnt;
    int busy_low;
    int first_valid;
    int busy_cnt;
  } res_t;

  typedef struct {
    int          f;
    int          l;
    int          stall;
    logic [31:0] v15;
    int          exp_err;
    int          exp_n;
    int          exp_done;
  } row_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bank_addr"}, longint'(bank_addr), 0);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_data"},  longint'(out_data),  0);
    chk({tag, "_out_index"}, longint'(out_index), 0);
    chk({tag, "_out_last"},  longint'(out_last),  0);
    chk({tag, "_busy"},      longint'(busy),      0);
    chk({tag, "_done"},      longint'(done),      0);
    chk({tag, "_error"},     longint'(error),     0);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 17; i++) mem[i] = 32'hA000_0000 + 32'(i);
  endtask

  // Issue one dump and observe it to completion. stall >= 0 holds ready low
  // for that many cycles of each word; stall < 0 drives random ready.
  task automatic run_dump(input int f, input int l, input int stall, input string tag,
                          output res_t r);
    word_t       q[$];
    word_t       w;
    logic        rng_ok;
    logic        pv;
    logic        finished;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    logic [4:0]  pa;
    logic [4:0]  addr0;
    int          wait_cnt;

    r = '{n: 0, done_cyc: -1, done_cnt: 0, err_cyc: -1, err_cnt: 0,
          busy_low: -1, first_valid: -1, busy_cnt: 0};
    rng_ok = (f <= l) && (l < 17);
    if (rng_ok)
      for (int i = f; i <= l; i++) q.push_back({mem[i], 5'(i), (i == l)});
    addr0     = bank_addr;
    pv        = 1'b0;
    pd        = '0;
    pi        = '0;
    pl        = 1'b0;
    pa        = '0;
    wait_cnt  = 0;
    finished  = 1'b0;
    start     = 1'b1;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    out_ready = 1'b0;
    @(posedge fast_clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      if (error) begin
        r.err_cnt++;
        if (r.err_cyc < 0) r.err_cyc = c;
      end
      if (busy) r.busy_cnt++;
      if (done) begin
        r.done_cnt++;
        if (r.done_cyc < 0) r.done_cyc = c;
      end
      if (r.busy_cnt > 0 && !busy && r.busy_low < 0) r.busy_low = c;
      if (out_valid) begin
        if (r.first_valid < 0) r.first_valid = c;
        if (pv) begin
          chk({tag, "_stall_data"},  longint'(out_data),  longint'(pd));
          chk({tag, "_stall_index"}, longint'(out_index), longint'(pi));
          chk({tag, "_stall_last"},  longint'(out_last),  longint'(pl));
          chk({tag, "_stall_addr"},  longint'(bank_addr), longint'(pa));
        end
        if (stall >= 0) out_ready = (wait_cnt >= stall);
        else            out_ready = 1'($urandom_range(0, 1));
        wait_cnt++;
        if (out_ready) begin
          if (q.size() == 0) begin
            chk({tag, "_extra_word"}, longint'(out_index), -1);
          end else begin
            w = q.pop_front();
            chk({tag, "_data"},  longint'(out_data),  longint'(w.d));
            chk({tag, "_index"}, longint'(out_index), longint'(w.i));
            chk({tag, "_last"},  longint'(out_last),  longint'(w.last));
            chk({tag, "_addr"},  longint'(bank_addr), longint'(w.i));
          end
          r.n++;
          pv       = 1'b0;
          wait_cnt = 0;
        end else begin
          pv = 1'b1;
          pd = out_data;
          pi = out_index;
          pl = out_last;
          pa = bank_addr;
        end
      end else begin
        out_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        pv = 1'b0;
      end
      finished = rng_ok ? (r.busy_low > 0) : (c >= 3);
      if (finished) break;
      @(posedge fast_clock); #1;
    end
    if (!finished) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_queue_left"}, longint'(q.size()), 0);
    if (!rng_ok) chk({tag, "_addr_unchanged"}, longint'(bank_addr), longint'(addr0));
    out_ready = 1'b0;
  endtask

  row_t tbl[6];
  res_t res;

  initial begin
    int   found;
    int   errs;
    int   dones;
    int   valids;
    int   f;
    int   l;
    int   tmp;
    logic rv;

    tbl[0] = '{f: 15, l: 15, stall: 0, v15: 32'h0000_0801, exp_err: -1, exp_n: 1,  exp_done: 4};
    tbl[1] = '{f: 0,  l: 16, stall: 0, v15: 32'hA000_000F, exp_err: -1, exp_n: 17, exp_done: 52};
    tbl[2] = '{f: 4,  l: 6,  stall: 5, v15: 32'hA000_000F, exp_err: -1, exp_n: 3,  exp_done: 25};
    tbl[3] = '{f: 7,  l: 3,  stall: 0, v15: 32'hA000_000F, exp_err: 1,  exp_n: 0,  exp_done: -1};
    tbl[4] = '{f: 0,  l: 17, stall: 0, v15: 32'hA000_000F, exp_err: 1,  exp_n: 0,  exp_done: -1};
    tbl[5] = '{f: 16, l: 16, stall: 2, v15: 32'hA000_000F, exp_err: -1, exp_n: 1,  exp_done: 6};

    reset     = 1'b0;
    start     = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    fill_pattern();
    repeat (3) @(posedge fast_clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
    @(posedge fast_clock); #1;

    // Directed table
    for (int k = 0; k < 6; k++) begin
      fill_pattern();
      mem[15] = tbl[k].v15;
      run_dump(tbl[k].f, tbl[k].l, tbl[k].stall, $sformatf("row%0d", k), res);
      chk($sformatf("row%0d_err_cyc", k),  res.err_cyc,  tbl[k].exp_err);
      chk($sformatf("row%0d_words", k),    res.n,        tbl[k].exp_n);
      chk($sformatf("row%0d_done_cyc", k), res.done_cyc, tbl[k].exp_done);
      if (tbl[k].exp_done > 0) begin
        chk($sformatf("row%0d_done_cnt", k),    res.done_cnt,    1);
        chk($sformatf("row%0d_busy_low", k),    res.busy_low,    tbl[k].exp_done + 1);
        chk($sformatf("row%0d_first_valid", k), res.first_valid, 3);
      end else begin
        chk($sformatf("row%0d_err_cnt", k),  res.err_cnt,  1);
        chk($sformatf("row%0d_busy_cnt", k), res.busy_cnt, 0);
      end
      @(posedge fast_clock); #1;
    end
    fill_pattern();

    // Abort during HOLD of index 2, with a mid-dump start that must be ignored
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd5; out_ready = 1'b0;
    @(posedge fast_clock); #1;
    start = 1'b0;
    found = 0;
    errs  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (error) errs++;
      if (c == 4) begin
        start = 1'b1; first_reg = 5'd7; last_reg = 5'd3;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_index == 5'd2) begin
        found = 1;
        break;
      end
      out_ready = out_valid;
      @(posedge fast_clock); #1;
    end
    start = 1'b0;
    chk("abort_reached_idx2", found, 1);
    abort = 1'b1; out_ready = 1'b0;
    @(posedge fast_clock); #1;
    abort = 1'b0;
    chk("abort_valid_drop", longint'(out_valid), 0);
    chk("abort_busy_drop",  longint'(busy), 0);
    chk("abort_addr_hold",  longint'(bank_addr), 2);
    dones = 0; valids = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      if (error) errs++;
      if (out_valid) valids++;
      @(posedge fast_clock); #1;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_no_error", errs, 0);
    chk("abort_stays_idle", valids, 0);

    // Abort in the same cycle as the last word is accepted
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd3; out_ready = 1'b0;
    @(posedge fast_clock); #1;
    start = 1'b0;
    found = 0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid) begin
        found = 1;
        break;
      end
      @(posedge fast_clock); #1;
    end
    chk("abacc_valid_seen", found, 1);
    chk("abacc_data", longint'(out_data), longint'(32'hA000_0003));
    abort = 1'b1; out_ready = 1'b1;
    @(posedge fast_clock); #1;
    abort = 1'b0; out_ready = 1'b0;
    chk("abacc_valid_drop", longint'(out_valid), 0);
    chk("abacc_busy_drop",  longint'(busy), 0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      @(posedge fast_clock); #1;
    end
    chk("abacc_no_done", dones, 0);

    // Reset during WAIT of index 9, then a fresh dump
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd16; out_ready = 1'b1;
    @(posedge fast_clock); #1;
    start = 1'b0;
    found = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bank_addr == 5'd9) begin
        found = 1;
        break;
      end
      @(posedge fast_clock); #1;
    end
    chk("rst_reached_idx9", found, 1);
    @(posedge fast_clock); #1;
    reset = 1'b0;
    @(posedge fast_clock); #1;
    check_reset_vals("rst_mid");
    reset = 1'b1; out_ready = 1'b0;
    @(posedge fast_clock); #1;
    run_dump(1, 1, 0, "post_rst", res);
    chk("post_rst_words", res.n, 1);
    chk("post_rst_done_cyc", res.done_cyc, 4);
    @(posedge fast_clock); #1;

    // Randomized dumps against the bank model
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 17; i++) mem[i] = $urandom;
      f = int'($urandom_range(0, 18));
      l = int'($urandom_range(0, 18));
      if (($urandom_range(0, 3) != 0) && (f > l)) begin
        tmp = f; f = l; l = tmp;
      end
      rv = (f <= l) && (l < 17);
      run_dump(f, l, -1, $sformatf("rnd%0d", k), res);
      chk($sformatf("rnd%0d_words", k),    res.n,       rv ? (l - f + 1) : 0);
      chk($sformatf("rnd%0d_err_cnt", k),  res.err_cnt, rv ? 0 : 1);
      chk($sformatf("rnd%0d_done_cnt", k), res.done_cnt, rv ? 1 : 0);
      @(posedge fast_clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_dump_reader.md
# regbank_dump_reader

Debug-side reader for the CPU register bank. On request it walks a contiguous range of register indices through one bank read port, captures each word after the bank's fixed read latency, and streams the words out over a valid/ready interface to a display, UART or debug host. It sits beside the register bank on the fast clock and never writes the bank.

## Interface

- REGISTER_LENGTH, 32, data word width
- NUM_REGS, 17, number of bank entries (indices 0..16; 14 = SP, 15 = PC, 16 = kernel SP)
- INDEX_WIDTH, 5, width of register indices
- READ_LATENCY, 1, fast_clock cycles from bank_addr change to valid bank_data (legal range 1..3)

Ports:

- fast_clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; sampled on the fast_clock rising edge
- start  in  1  request pulse; sampled only in IDLE
- first_reg  in  INDEX_WIDTH  first index of range; sampled with start
- last_reg  in  INDEX_WIDTH  last index of range, inclusive; sampled with start
- abort  in  1  cancel the dump in progress
- bank_addr  out  INDEX_WIDTH  read address to the bank read port
- bank_data  in  REGISTER_LENGTH  bank read data
- out_valid  out  1  out_data / out_index / out_last are valid
- out_ready  in  1  consumer accepts the word
- out_data  out  REGISTER_LENGTH  captured register value
- out_index  out  INDEX_WIDTH  index of out_data
- out_last  out  1  current word is the last of the range
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the range completes normally
- error  out  1  one-cycle pulse when a start request is rejected

## Operation

- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE + start=1:
  - Range valid (first_reg <= last_reg and last_reg < NUM_REGS): latch first_reg as the current index and last_reg as the end index, then go to ISSUE.
  - Range invalid: pulse error for one cycle and stay in IDLE.
- ISSUE: drive bank_addr = current index, load the latency counter with READ_LATENCY, go to WAIT.
- WAIT: decrement the counter. When it reaches its final count, load out_data = bank_data, out_index = current index, and out_last = (current index == end index). Assert out_valid and go to HOLD.
- HOLD: hold out_valid and the payload stable until out_valid && out_ready.
  - On acceptance with out_last=1: go to DONE.
  - Otherwise: increment the current index and go to ISSUE.
- DONE: pulse done for one cycle, then return to IDLE.
- bank_addr holds its last driven value outside ISSUE. It changes only in ISSUE.
- start outside IDLE is ignored, with no error.
- abort=1 in any non-IDLE state: next state is IDLE. out_valid drops the next cycle whether or not the word was accepted. No done pulse is generated.
- abort and acceptance in the same cycle: abort wins and no done pulse is generated. The consumer has taken the word.
- Range wrap-around is impossible, because last_reg < NUM_REGS is checked at start.

## Timing

- Reset values: bank_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, error=0. FSM state is IDLE.
- Reset mid-dump: all outputs take their reset values on the next edge and the latched range is discarded.
- Cycle numbering: start is sampled at edge 0. ISSUE occupies cycle 1. WAIT occupies cycles 2..1+READ_LATENCY. out_valid is first high in cycle 2+READ_LATENCY.
- Per-word cost with out_ready held high: 2+READ_LATENCY cycles (3 cycles for the default latency).
- Full 17-word dump at default latency with ready held high:
  - last acceptance in cycle 51
  - done high in cycle 52
  - busy low from cycle 53
- error is high in cycle 1 after a rejected start.
- busy rises in cycle 1 after an accepted start.
- No combinational path from out_ready to out_valid or to the payload.

## Test plan

- Single word, default latency: bank index 15 = 0x00000801; start with first_reg=15, last_reg=15, out_ready=1 → out_valid in cycle 3 with out_data=0x801, out_index=15, out_last=1; done pulse in cycle 4.
- Full dump, ready held high: bank[i] = 0xA000_0000+i, range 0..16 → 17 words in order with values 0xA0000000..0xA0000010; out_last only on index 16; words accepted 3 cycles apart; done in cycle 52.
- Backpressure: range 4..6 with out_ready low for 5 cycles on each word → payload and bank_addr stable while stalled; exactly 3 acceptances; indices 4, 5, 6.
- Invalid ranges: (first=7, last=3) and (first=0, last=17) → one-cycle error pulse each; busy stays 0; bank_addr unchanged.
- Abort and start while busy: abort during HOLD of index 2 in range 0..5 → IDLE next cycle, out_valid=0, no done pulse; a start issued mid-dump is ignored with no error.
- Reset mid-dump: reset=0 during WAIT of index 9 → all outputs 0 next cycle; a new start with range 1..1 then completes normally.
